// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction/tag in, decoded immediate/format/tag out.
// The slave modport is the generator's view; the master modport is the producer/consumer view.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_imm;
    logic [2:0]        out_fmt;
    logic              out_illeg;
    logic [TAG_W-1:0]  out_tag;
    logic [15:0]       illeg_cnt;

    modport slave (
        input  in_valid, in_inst, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illeg, out_tag, illeg_cnt
    );

    modport master (
        output in_valid, in_inst, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illeg, out_tag, illeg_cnt
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator: decodes I/S/B/U/J from the opcode and sign-extends to XLEN.
// Two entries of storage (output register + skid entry) with a registered in_ready.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input logic           clk,
    input logic           rst,
    imm_gen_pipe_if.slave bus
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam int unsigned CNT_W   = 16;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             illeg;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_t;

    state_t           state;
    state_t           state_n;
    entry_t           out_q;
    entry_t           out_n;
    entry_t           skid_q;
    entry_t           skid_n;
    entry_t           dec;
    logic [31:0]      inst;
    logic [31:0]      imm32;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [CNT_W-1:0] illeg_cnt_q;
    logic             accept;
    logic             drain;

    assign inst   = bus.in_inst;
    assign accept = bus.in_valid && in_ready_q;
    assign drain  = out_valid_q && bus.out_ready;

    // Format decode and 32-bit immediate assembly; widened to XLEN by sign extension
    always_comb begin
        imm32     = 32'd0;
        dec       = '0;
        dec.tag   = bus.in_tag;
        dec.fmt   = FMT_NONE;
        dec.illeg = 1'b0;
        case (inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                dec.fmt = FMT_I;
                imm32   = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                imm32   = {inst[31:12], 12'd0};
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: begin
                dec.illeg = 1'b1;
            end
        endcase
        dec.imm = XLEN'($signed(imm32));
    end

    // Occupancy FSM: next state and next contents of the output and skid registers
    always_comb begin
        state_n = state;
        out_n   = out_q;
        skid_n  = skid_q;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    out_n   = dec;
                    state_n = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && drain) begin
                    out_n = dec;
                end else if (accept) begin
                    skid_n  = dec;
                    state_n = S_TWO;
                end else if (drain) begin
                    state_n = S_EMPTY;
                end
            end
            S_TWO: begin
                // in_ready is low here, so only a drain can happen
                if (drain) begin
                    out_n   = skid_q;
                    state_n = S_ONE;
                end
            end
            default: begin
                state_n = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            illeg_cnt_q <= '0;
        end else begin
            state       <= state_n;
            out_q       <= out_n;
            skid_q      <= skid_n;
            out_valid_q <= (state_n != S_EMPTY);
            in_ready_q  <= (state_n != S_TWO);
            if (accept && dec.illeg && (illeg_cnt_q != {CNT_W{1'b1}})) begin
                illeg_cnt_q <= illeg_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_imm   = out_q.imm;
    assign bus.out_fmt   = out_q.fmt;
    assign bus.out_illeg = out_q.illeg;
    assign bus.out_tag   = out_q.tag;
    assign bus.illeg_cnt = illeg_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: table-driven vectors through a scoreboard, plus stall/fill/reset sequences.
module tb_imm_gen_pipe;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        illeg;
    } vec_t;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        illeg;
        logic [31:0] tag;
    } exp_t;

    localparam int NV = 15;

    logic   clk;
    logic   rst;
    logic   rdy_force;
    logic   rand_rdy;
    logic   rnd_bit;
    int     n_cmp;
    int     n_err;
    int     cyc;
    int     exp_cnt;
    exp_t   sb[$];
    exp_t   cur_exp;
    exp_t   held;
    logic   held_vld;
    vec_t   vecs[NV];

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) ifc ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) ifc64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
        .clk (clk),
        .rst (rst),
        .bus (ifc64.slave)
    );

    assign ifc.out_ready   = rand_rdy ? rnd_bit : rdy_force;
    assign ifc64.out_ready = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rnd_bit <= 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: push on input handshake, pop/compare on output handshake, check stability while stalled
    always @(negedge clk) begin
        if (rst) begin
            held_vld = 1'b0;
        end else begin
            if (held_vld) begin
                if (ifc.out_valid) begin
                    chk("stable_imm", 64'(ifc.out_imm), 64'(held.imm));
                    chk("stable_tag", 64'(ifc.out_tag), 64'(held.tag));
                end else begin
                    chk("stable_valid", 64'(ifc.out_valid), 64'd1);
                end
            end
            if (ifc.out_valid && ifc.out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow_tag", 64'(ifc.out_tag), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_imm",   64'(ifc.out_imm),   64'(e.imm));
                    chk("sb_fmt",   64'(ifc.out_fmt),   64'(e.fmt));
                    chk("sb_illeg", 64'(ifc.out_illeg), 64'(e.illeg));
                    chk("sb_tag",   64'(ifc.out_tag),   64'(e.tag));
                end
                held_vld = 1'b0;
            end else if (ifc.out_valid) begin
                held.imm   = ifc.out_imm;
                held.fmt   = ifc.out_fmt;
                held.illeg = ifc.out_illeg;
                held.tag   = ifc.out_tag;
                held_vld   = 1'b1;
            end else begin
                held_vld = 1'b0;
            end
            if (ifc.in_valid && ifc.in_ready) begin
                sb.push_back(cur_exp);
                if (cur_exp.illeg) exp_cnt++;
            end
        end
    end

    task automatic present(input int idx, input logic [31:0] tag);
        ifc.in_valid  = 1'b1;
        ifc.in_inst   = vecs[idx].inst;
        ifc.in_tag    = tag;
        cur_exp.imm   = vecs[idx].imm;
        cur_exp.fmt   = vecs[idx].fmt;
        cur_exp.illeg = vecs[idx].illeg;
        cur_exp.tag   = tag;
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifc.in_ready && n < 60);
        if (!ifc.in_ready) chk("accept_timeout", 64'(ifc.in_ready), 64'd1);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic send(input int idx, input logic [31:0] tag);
        present(idx, tag);
        wait_accept();
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
        #1;
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0};
        vecs[1]  = '{32'hFE20AE23, 32'hFFFFFFFC, 3'd2, 1'b0};
        vecs[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0};
        vecs[3]  = '{32'h123452B7, 32'h12345000, 3'd4, 1'b0};
        vecs[4]  = '{32'h0010006F, 32'h00000800, 3'd5, 1'b0};
        vecs[5]  = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1};
        vecs[6]  = '{32'hFFFFFFFF, 32'h00000000, 3'd0, 1'b1};
        vecs[7]  = '{32'h00008067, 32'h00000000, 3'd1, 1'b0};
        vecs[8]  = '{32'h80002083, 32'hFFFFF800, 3'd1, 1'b0};
        vecs[9]  = '{32'h00000073, 32'h00000000, 3'd1, 1'b0};
        vecs[10] = '{32'hFFFFF097, 32'hFFFFF000, 3'd4, 1'b0};
        vecs[11] = '{32'h002081B3, 32'h00000000, 3'd0, 1'b1};
        vecs[12] = '{32'h7E000FA3, 32'h000007FF, 3'd2, 1'b0};
        vecs[13] = '{32'h8000006F, 32'hFFF00000, 3'd5, 1'b0};
        vecs[14] = '{32'h00000063, 32'h00000000, 3'd3, 1'b0};

        n_cmp = 0; n_err = 0; cyc = 0; exp_cnt = 0; held_vld = 1'b0;
        rst = 1'b1; rdy_force = 1'b0; rand_rdy = 1'b0;
        ifc.in_valid = 1'b0; ifc.in_inst = 32'd0; ifc.in_tag = 32'd0;
        ifc64.in_valid = 1'b0; ifc64.in_inst = 32'd0; ifc64.in_tag = 32'd0;
        cur_exp = '{32'd0, 3'd0, 1'b0, 32'd0};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("rst_out_imm",   64'(ifc.out_imm),   64'd0);
        chk("rst_out_fmt",   64'(ifc.out_fmt),   64'd0);
        chk("rst_out_illeg", 64'(ifc.out_illeg), 64'd0);
        chk("rst_out_tag",   64'(ifc.out_tag),   64'd0);
        chk("rst_illeg_cnt", 64'(ifc.illeg_cnt), 64'd0);
        chk("rst_in_ready",  64'(ifc.in_ready),  64'd1);

        // One-cycle latency through an empty pipe
        rdy_force = 1'b1;
        present(0, 32'd1);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        chk("lat_valid", 64'(ifc.out_valid), 64'd1);
        chk("lat_imm",   64'(ifc.out_imm),   64'hFFFFFFFF);
        chk("lat_fmt",   64'(ifc.out_fmt),   64'd1);
        chk("lat_illeg", 64'(ifc.out_illeg), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_drained", 64'(ifc.out_valid), 64'd0);

        // Full table streamed with out_ready held high: one entry per cycle
        begin
            int t0;
            t0 = cyc;
            for (int i = 0; i < NV; i++) send(i, 32'(100 + i));
            chk("throughput_cycles", 64'(cyc - t0), 64'(NV));
        end
        wait_drain();
        chk("illeg_cnt_pass1", 64'(ifc.illeg_cnt), 64'(exp_cnt));

        // Same table against a randomly stalling consumer
        rand_rdy = 1'b1;
        for (int i = 0; i < NV; i++) send(i, 32'(200 + i));
        wait_drain();
        rand_rdy = 1'b0;
        chk("illeg_cnt_pass2", 64'(ifc.illeg_cnt), 64'(exp_cnt));

        // Fill under stall: third word refused, then drained in order
        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        present(3, 32'd1);
        @(posedge clk);
        #1;
        present(4, 32'd2);
        @(posedge clk);
        #1;
        present(1, 32'd3);
        chk("full_in_ready", 64'(ifc.in_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("full_in_ready_hold", 64'(ifc.in_ready), 64'd0);
        chk("full_out_tag",       64'(ifc.out_tag),  64'd1);
        chk("full_sb_size",       64'(sb.size()),    64'd2);
        rdy_force = 1'b1;
        wait_accept();
        wait_drain();

        // Illegal words bump the counter and present zero immediates
        begin
            int c0;
            c0 = exp_cnt;
            send(5, 32'd50);
            send(6, 32'd51);
            wait_drain();
            chk("illeg_cnt_plus2", 64'(ifc.illeg_cnt), 64'(c0 + 2));
        end

        // Reset while both entries are held
        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        send(5, 32'd300);
        send(3, 32'd301);
        chk("pre_rst_in_ready", 64'(ifc.in_ready), 64'd0);
        rst = 1'b1;
        present(10, 32'd302);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifc.in_valid = 1'b0;
        sb.delete();
        exp_cnt = 0;
        chk("mid_rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("mid_rst_illeg_cnt", 64'(ifc.illeg_cnt), 64'd0);
        chk("mid_rst_in_ready",  64'(ifc.in_ready),  64'd1);
        chk("mid_rst_out_tag",   64'(ifc.out_tag),   64'd0);
        rdy_force = 1'b1;
        present(13, 32'd303);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        chk("post_rst_valid", 64'(ifc.out_valid), 64'd1);
        chk("post_rst_tag",   64'(ifc.out_tag),   64'd303);
        chk("post_rst_imm",   64'(ifc.out_imm),   64'hFFF00000);
        wait_drain();

        // XLEN=64 sign extension
        ifc64.in_valid = 1'b1;
        ifc64.in_inst  = 32'hFFF00093;
        ifc64.in_tag   = 32'd7;
        @(posedge clk);
        #1;
        ifc64.in_inst  = 32'h800002B7;
        chk("x64_addi_imm", ifc64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("x64_addi_fmt", 64'(ifc64.out_fmt), 64'd1);
        @(posedge clk);
        #1;
        ifc64.in_valid = 1'b0;
        chk("x64_lui_imm", ifc64.out_imm, 64'hFFFF_FFFF_8000_0000);
        chk("x64_lui_fmt", 64'(ifc64.out_fmt), 64'd4);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
